regfile_mp: RTL and testbench

Parametrised multi-port register file for the 16-bit single-cycle CPU datapath. It is the next generation of the core register file and adds:
- N asynchronous read ports
- a dedicated write address
- optional hardwired-zero entry 0
- optional write-to-read bypass
- a sequential clear engine, so the storage array carries no reset and maps to distributed RAM

The block sits between decode (read addresses), writeback (write port) and the control unit, which observes `clr_busy`.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_fsm.sv | 70 +++++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
// The datapath imports the default WIDTH/DEPTH values from here so that both sides agree.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: sweeps zeros through every entry after reset or on request.
// It holds the only reset state of the register file, so the array itself can map to plain RAM.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic                 sweep_we,
    output logic [ADDR_SIZE-1:0] sweep_addr
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

    clr_state_t           state_q, state_d;
    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        sweep_we = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_SWEEP;
                    ptr_d   = '0;
                end
            end
            CLR_SWEEP: begin
                clr_busy = 1'b1;
                sweep_we = 1'b1;
                // Stop on the last entry rather than wrapping the pointer.
                if (ptr_q == LAST_ADDR) begin
                    state_d = CLR_DONE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            CLR_DONE: begin
                clr_done = 1'b1;
                state_d  = CLR_IDLE;
            end
            default: begin
                state_d = CLR_SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    assign sweep_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, one write port, optional
// hardwired-zero entry 0, optional write-to-read bypass, and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned ADDR_SIZE = $clog2(DEPTH),
    parameter int unsigned NREAD     = 2,
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREAD*ADDR_SIZE-1:0] raddr,
    output logic [NREAD*WIDTH-1:0]     rdata,
    input  logic                       we,
    input  logic [ADDR_SIZE-1:0]       waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 sweep_we;
    logic [ADDR_SIZE-1:0] sweep_addr;
    logic                 ext_we;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WIDTH-1:0]     mem_wdata;

    regfile_clear_fsm #(
        .DEPTH     (DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // A dropped write (busy or entry 0 hardwired) must also not bypass to the read ports.
    assign ext_we = we && !clr_busy && !(ZERO_REG && (waddr == '0));

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = waddr;
        mem_wdata = wdata;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_addr;
            mem_wdata = '0;
        end else if (ext_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_SIZE-1:0] ra;
        logic [WIDTH-1:0]     rd;

        assign ra = raddr[i*ADDR_SIZE +: ADDR_SIZE];

        always_comb begin
            rd = mem[ra];
            if (clr_busy) begin
                rd = '0;
            end else if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end else if (BYPASS && ext_we && (waddr == ra)) begin
                rd = wdata;
            end
        end

        assign rdata[i*WIDTH +: WIDTH] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised plus directed bench for regfile_mp (NREAD=3, ZERO_REG=1, BYPASS=1) using a
// cycle-level reference model and an expectation queue drained by a separate monitor.
module tb_regfile_mp;

    localparam int W  = 16;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [NR*W-1:0] rd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*W-1:0] rdata;
    logic            we = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [W-1:0]    wdata = '0;
    logic            clr_req = 1'b0;
    logic            clr_busy;
    logic            clr_done;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model: contents, remaining busy cycles, and a one-cycle done flag.
    logic [W-1:0] mref [D];
    int           busy_left = D;
    bit           done_flag = 1'b0;

    regfile_mp #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ADDR_SIZE(AW),
        .NREAD    (NR),
        .ZERO_REG (1'b1),
        .BYPASS   (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raddr   (raddr),
        .rdata   (rdata),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] ra);
        if (rst || busy_left > 0) return '0;
        if (ra == 0) return '0;
        if (we && waddr == ra) return wdata;
        return mref[ra];
    endfunction

    task automatic model_edge();
        bit was_done;
        if (rst) begin
            busy_left = D;
            done_flag = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                done_flag = 1'b1;
                for (int k = 0; k < D; k++) mref[k] = '0;
            end
        end else begin
            was_done  = done_flag;
            done_flag = 1'b0;
            if (we && waddr != 0) mref[waddr] = wdata;
            if (!was_done && clr_req) busy_left = D;
        end
    endtask

    // Drive one cycle: apply inputs, queue the expected outputs, advance the model at the edge.
    task automatic drive(input logic r, input logic c, input logic w, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic [AW-1:0] r0,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        exp_t e;
        rst     = r;
        clr_req = c;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        raddr   = {r2, r1, r0};
        e.busy  = rst || (busy_left > 0);
        e.done  = !rst && done_flag;
        e.rd    = {model_read(r2), model_read(r1), model_read(r0)};
        exp_q.push_back(e);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, AW'($urandom_range(0, D - 1)),
                  AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)));
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response to check.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (clr_busy !== e.busy) begin
                errors++;
                $display("FAIL clr_busy t=%0t actual=%0b required=%0b", $time, clr_busy, e.busy);
            end
            checks++;
            if (clr_done !== e.done) begin
                errors++;
                $display("FAIL clr_done t=%0t actual=%0b required=%0b", $time, clr_done, e.done);
            end
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (rdata[p*W +: W] !== e.rd[p*W +: W]) begin
                    errors++;
                    $display("FAIL rdata%0d t=%0t raddr=%0d actual=%h required=%h", p, $time,
                             raddr[p*AW +: AW], rdata[p*W +: W], e.rd[p*W +: W]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < D; k++) mref[k] = '0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles, then the full sweep and the done pulse.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, '0, '0, 5'd0, 5'd1, 5'd2);
        idle(D + 2);
        for (int a = 0; a < D; a += 3) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, AW'(a), AW'((a + 1) % D), AW'((a + 2) % D));
        end

        // Bypass in the write cycle, then array readback.
        drive(1'b0, 1'b0, 1'b1, 5'd5, 16'hBEEF, 5'd5, 5'd5, 5'd4);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd5, 5'd0, 5'd5);

        // Hardwired zero entry.
        drive(1'b0, 1'b0, 1'b1, 5'd0, 16'h1234, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 5'd0);

        // Multi-port reads.
        drive(1'b0, 1'b0, 1'b1, 5'd1, 16'h0011, 5'd1, 5'd2, 5'd3);
        drive(1'b0, 1'b0, 1'b1, 5'd2, 16'h0022, 5'd1, 5'd2, 5'd3);
        drive(1'b0, 1'b0, 1'b1, 5'd3, 16'h0033, 5'd1, 5'd2, 5'd3);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd3, 5'd1, 5'd2);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd2, 5'd2, 5'd2);

        // Write with clr_req commits then gets swept; write in sweep cycle 2 is dropped.
        drive(1'b0, 1'b1, 1'b1, 5'd31, 16'hAAAA, 5'd31, 5'd3, 5'd1);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 5'd31, 5'd3, 5'd1);
        drive(1'b0, 1'b0, 1'b1, 5'd3, 16'h5555, 5'd31, 5'd3, 5'd1);
        idle(D - 2);
        drive(1'b0, 1'b1, 1'b1, 5'd3, 16'h7777, 5'd3, 5'd31, 5'd3);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd3, 5'd31, 5'd1);

        // Reset in sweep cycle 10 for 2 cycles restarts the full sweep.
        drive(1'b0, 1'b1, 1'b0, '0, '0, 5'd1, 5'd2, 5'd3);
        idle(9);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 5'd1, 5'd2, 5'd3);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 5'd1, 5'd2, 5'd3);
        idle(D + 3);

        // Random traffic with occasional clear requests and resets.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 1), AW'($urandom_range(0, D - 1)),
                  W'($urandom), AW'($urandom_range(0, D - 1)),
                  AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)));
        end
        idle(D + 3);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
